// File: rtl/rc4_pkg.sv
// Shared types and limits for the RC4 stream cipher.
package rc4_pkg;

    localparam int unsigned MAX_KEY_LEN = 32;
    localparam int unsigned MAX_DROP    = 4095;
    localparam int unsigned KEY_IDX_W   = 5;
    localparam int unsigned DROP_CNT_W  = 12;
    localparam int unsigned SBOX_DEPTH  = 256;

    typedef logic [7:0] byte_t;
    typedef byte_t sbox_t [SBOX_DEPTH];

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_KSA  = 2'd1,
        ST_DROP = 2'd2,
        ST_RUN  = 2'd3
    } rc4_state_e;

    // Byte addition wrapping mod 256.
    function automatic byte_t byte_add(input byte_t a, input byte_t b);
        return 8'(a + b);
    endfunction

endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation table: identity load, two-address swap and a keystream
// read port that sees the permutation as it will be after the swap.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic  clk,
    input  logic  init,
    input  logic  swap_en,
    input  byte_t addr_a,
    input  byte_t addr_b,
    output byte_t rd_a_c,
    output byte_t rd_k_c
);

    sbox_t mem;
    byte_t rd_b_c;
    byte_t addr_k_c;

    assign rd_a_c   = mem[addr_a];
    assign rd_b_c   = mem[addr_b];
    assign addr_k_c = byte_add(rd_a_c, rd_b_c);

    // Keystream lookup; the two swapped entries are forwarded crosswise.
    always_comb begin
        rd_k_c = mem[addr_k_c];
        if (addr_k_c == addr_a) begin
            rd_k_c = rd_b_c;
        end else if (addr_k_c == addr_b) begin
            rd_k_c = rd_a_c;
        end
    end

    // Identity load takes priority over the swap write.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < int'(SBOX_DEPTH); k++) begin
                mem[k] <= 8'(k);
            end
        end else if (swap_en) begin
            mem[addr_a] <= rd_b_c;
            mem[addr_b] <= rd_a_c;
        end
    end

endmodule

// File: rtl/rc4_stream_cipher.sv
// RC4 (optionally RC4-drop[N]) byte-stream cipher with valid/ready input.
module rc4_stream_cipher
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_LEN = 16,
    parameter int unsigned DROP_N  = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  byte_t seed [KEY_LEN],
    input  logic  key_load,
    input  byte_t din,
    input  logic  din_valid,
    output logic  din_ready,
    output byte_t dout,
    output logic  dout_ready,
    output logic  init_done
);

    localparam logic [KEY_IDX_W-1:0]  KEY_LAST  = KEY_IDX_W'(KEY_LEN - 1);
    localparam logic [DROP_CNT_W-1:0] DROP_LAST =
        (DROP_N > 0) ? DROP_CNT_W'(DROP_N - 1) : '0;

    // Reject illegal parameterisations at elaboration.
    if (KEY_LEN < 1 || KEY_LEN > MAX_KEY_LEN) begin : g_bad_key_len
        $error("rc4_stream_cipher: KEY_LEN must be 1..32");
    end
    if (DROP_N > MAX_DROP) begin : g_bad_drop
        $error("rc4_stream_cipher: DROP_N must be 0..4095");
    end

    rc4_state_e            state;
    rc4_state_e            state_next;
    byte_t                 i;
    byte_t                 j;
    logic [KEY_IDX_W-1:0]  kx;
    logic [DROP_CNT_W-1:0] drop_cnt;
    byte_t                 key_reg  [MAX_KEY_LEN];
    byte_t                 key_seed [MAX_KEY_LEN];

    logic  sbox_init;
    logic  ksa_step;
    logic  prga_step;
    logic  accept;
    byte_t addr_a_c;
    byte_t s_a_c;
    byte_t key_byte_c;
    byte_t j_next_c;
    byte_t ks_c;

    // Seed zero-padded to the maximum key width so kx never indexes out of range.
    for (genvar g = 0; g < int'(MAX_KEY_LEN); g++) begin : g_key
        if (g < KEY_LEN) begin : g_used
            assign key_seed[g] = seed[g];
        end else begin : g_pad
            assign key_seed[g] = '0;
        end
    end

    // KSA reads S[i] and adds the key byte; PRGA reads S[i+1] only.
    assign addr_a_c   = (state == ST_KSA) ? i : 8'(i + 8'd1);
    assign key_byte_c = (state == ST_KSA) ? key_reg[kx] : 8'd0;
    assign j_next_c   = 8'(j + s_a_c + key_byte_c);

    assign din_ready = (state == ST_RUN) && !key_load;
    assign accept    = din_valid && din_ready;

    rc4_sbox u_sbox (
        .clk     (clk),
        .init    (sbox_init),
        .swap_en (ksa_step | prga_step),
        .addr_a  (addr_a_c),
        .addr_b  (j_next_c),
        .rd_a_c  (s_a_c),
        .rd_k_c  (ks_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and step control; key_load overrides everything.
    always_comb begin
        state_next = state;
        sbox_init  = 1'b0;
        ksa_step   = 1'b0;
        prga_step  = 1'b0;
        unique case (state)
            ST_INIT: begin
                sbox_init  = 1'b1;
                state_next = ST_KSA;
            end
            ST_KSA: begin
                ksa_step = 1'b1;
                if (i == 8'hFF) begin
                    state_next = (DROP_N > 0) ? ST_DROP : ST_RUN;
                end
            end
            ST_DROP: begin
                prga_step = 1'b1;
                if (drop_cnt == DROP_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                prga_step = accept;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
        if (key_load) begin
            state_next = ST_INIT;
            sbox_init  = 1'b0;
            ksa_step   = 1'b0;
            prga_step  = 1'b0;
        end
    end

    // Index registers: cleared in INIT, advanced by KSA and PRGA steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i        <= '0;
            j        <= '0;
            kx       <= '0;
            drop_cnt <= '0;
        end else if (ksa_step) begin
            i  <= 8'(i + 8'd1);
            j  <= (i == 8'hFF) ? 8'd0 : j_next_c;
            kx <= (kx == KEY_LAST) ? '0 : kx + 1'b1;
        end else if (prga_step) begin
            i <= addr_a_c;
            j <= j_next_c;
            if (state == ST_DROP) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (state == ST_INIT) begin
            i        <= '0;
            j        <= '0;
            kx       <= '0;
            drop_cnt <= '0;
        end
    end

    // Key is sampled only during INIT so later seed changes wait for the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_reg <= '{default: '0};
        end else if (state == ST_INIT) begin
            key_reg <= key_seed;
        end
    end

    // Registered outputs; dout holds between accepted bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_ready <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            dout_ready <= accept;
            init_done  <= (state_next == ST_RUN);
            if (accept) begin
                dout <= din ^ ks_c;
            end
        end
    end

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Directed-vector bench for rc4_stream_cipher using four parameterisations.
`timescale 1ns/1ps
module tb_rc4_stream_cipher;
    import rc4_pkg::*;

    localparam int unsigned NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_n;
    logic [NI-1:0] key_load;
    logic [NI-1:0] din_valid;
    logic [NI-1:0] din_ready;
    logic [NI-1:0] dout_ready;
    logic [NI-1:0] init_done;
    byte_t         din  [NI];
    byte_t         dout [NI];

    byte_t seed_key    [3];
    byte_t seed_secret [6];
    byte_t seed_num    [5];

    byte_t pt_plain  [16];
    byte_t ct_plain  [16];
    byte_t pt_attack [16];
    byte_t ct_attack [16];
    byte_t pt_zero   [16];
    byte_t ct_num    [16];
    byte_t ct_drop   [16];

    int n_checks = 0;
    int n_errors = 0;

    rc4_stream_cipher #(.KEY_LEN(3), .DROP_N(0)) u_key (
        .clk(clk), .rst_n(rst_n[0]), .seed(seed_key), .key_load(key_load[0]),
        .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
        .dout(dout[0]), .dout_ready(dout_ready[0]), .init_done(init_done[0])
    );

    rc4_stream_cipher #(.KEY_LEN(6), .DROP_N(0)) u_secret (
        .clk(clk), .rst_n(rst_n[1]), .seed(seed_secret), .key_load(key_load[1]),
        .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
        .dout(dout[1]), .dout_ready(dout_ready[1]), .init_done(init_done[1])
    );

    rc4_stream_cipher #(.KEY_LEN(5), .DROP_N(0)) u_num (
        .clk(clk), .rst_n(rst_n[2]), .seed(seed_num), .key_load(key_load[2]),
        .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
        .dout(dout[2]), .dout_ready(dout_ready[2]), .init_done(init_done[2])
    );

    rc4_stream_cipher #(.KEY_LEN(5), .DROP_N(4)) u_drop (
        .clk(clk), .rst_n(rst_n[3]), .seed(seed_num), .key_load(key_load[3]),
        .din(din[3]), .din_valid(din_valid[3]), .din_ready(din_ready[3]),
        .dout(dout[3]), .dout_ready(dout_ready[3]), .init_done(init_done[3])
    );

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Count edges until init_done rises; called at the negedge after the restart edge.
    task automatic wait_init(input int id, input int exp_edges, input string tag);
        int n;
        n = 0;
        while (!init_done[id] && n <= 600) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s u%0d init edges", tag, id), 32'(n), 32'(exp_edges));
    endtask

    // Reset one instance for one edge, verify cleared outputs, then wait for init.
    task automatic restart(input int id, input int exp_edges, input string tag);
        rst_n[id] = 1'b0;
        @(negedge clk);
        check($sformatf("%s u%0d rst dout", tag, id), 32'(dout[id]), 32'h0);
        check($sformatf("%s u%0d rst dout_ready", tag, id), 32'(dout_ready[id]), 32'h0);
        check($sformatf("%s u%0d rst init_done", tag, id), 32'(init_done[id]), 32'h0);
        check($sformatf("%s u%0d rst din_ready", tag, id), 32'(din_ready[id]), 32'h0);
        din_valid[id] = 1'b0;
        rst_n[id]     = 1'b1;
        wait_init(id, exp_edges, tag);
    endtask

    // Stream n bytes; a set bit in gaps idles that cycle slot.
    task automatic run_bytes(input int id, input int n, input byte_t pt [16],
                             input byte_t ct [16], input logic [31:0] gaps,
                             input string tag);
        int    b;
        int    s;
        byte_t last;
        b    = 0;
        s    = 0;
        last = dout[id];
        check($sformatf("%s u%0d din_ready", tag, id), 32'(din_ready[id]), 32'h1);
        while (b < n && s < 32) begin
            if (gaps[s]) begin
                din_valid[id] = 1'b0;
                @(negedge clk);
                check($sformatf("%s gap%0d dout_ready", tag, s), 32'(dout_ready[id]), 32'h0);
                check($sformatf("%s gap%0d dout hold", tag, s), 32'(dout[id]), 32'(last));
            end else begin
                din[id]       = pt[b];
                din_valid[id] = 1'b1;
                @(negedge clk);
                check($sformatf("%s byte%0d dout_ready", tag, b), 32'(dout_ready[id]), 32'h1);
                check($sformatf("%s byte%0d dout", tag, b), 32'(dout[id]), 32'(ct[b]));
                last = ct[b];
                b++;
            end
            s++;
        end
        din_valid[id] = 1'b0;
        @(negedge clk);
        check($sformatf("%s idle dout_ready", tag), 32'(dout_ready[id]), 32'h0);
        check($sformatf("%s idle dout hold", tag), 32'(dout[id]), 32'(last));
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = '0;
        key_load  = '0;
        din_valid = '0;
        for (int k = 0; k < int'(NI); k++) din[k] = 8'h00;
        seed_key    = '{8'h4B, 8'h65, 8'h79};
        seed_secret = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
        seed_num    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        pt_plain  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78,
                      8'h74, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ct_plain  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A,
                      8'hD3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pt_attack = '{8'h41, 8'h74, 8'h74, 8'h61, 8'h63, 8'h6B, 8'h20, 8'h61,
                      8'h74, 8'h20, 8'h64, 8'h61, 8'h77, 8'h6E, 8'h00, 8'h00};
        ct_attack = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38,
                      8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5, 8'h00, 8'h00};
        pt_zero   = '{default: 8'h00};
        ct_num    = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ct_drop   = '{8'hF0, 8'h3D, 8'hC0, 8'h27, 8'hCC, 8'hC3, 8'h52, 8'h4A,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        @(negedge clk);

        // "Key" / "Plaintext", back-to-back.
        restart(0, 257, "key");
        run_bytes(0, 9, pt_plain, ct_plain, 32'h0, "plain");

        // "Secret" / "Attack at dawn" with idle slots 1, 5 and 8.
        restart(1, 257, "secret");
        run_bytes(1, 14, pt_attack, ct_attack, 32'h0000_0122, "attack");

        // 0102030405 zero stream, then key reload with a colliding valid byte.
        restart(2, 257, "num");
        run_bytes(2, 8, pt_zero, ct_num, 32'h0, "num");
        din[2]       = 8'h00;
        din_valid[2] = 1'b1;
        key_load[2]  = 1'b1;
        #1;
        check("reload din_ready", 32'(din_ready[2]), 32'h0);
        @(negedge clk);
        check("reload dout_ready", 32'(dout_ready[2]), 32'h0);
        check("reload init_done", 32'(init_done[2]), 32'h0);
        check("reload dout hold", 32'(dout[2]), 32'h27);
        key_load[2]  = 1'b0;
        din_valid[2] = 1'b0;
        wait_init(2, 257, "reload");
        run_bytes(2, 8, pt_zero, ct_num, 32'h0, "num again");

        // Same key with four keystream bytes dropped.
        restart(3, 261, "drop");
        run_bytes(3, 8, pt_zero, ct_drop, 32'h0, "drop");

        // Abort in the middle of KSA.
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (100) @(negedge clk);
        restart(0, 257, "ksa abort");
        run_bytes(0, 5, pt_plain, ct_plain, 32'h0, "plain head");

        // Abort during RUN with a byte offered in the reset cycle.
        din[0]       = 8'h74;
        din_valid[0] = 1'b1;
        restart(0, 257, "run abort");
        run_bytes(0, 9, pt_plain, ct_plain, 32'h0, "plain rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
